// File: rtl/fp_add_issuer.sv
// fp_add_issuer
//   Takes one multi-lane floating-point add request, issues its lanes one at a
//   time to a single-lane adder, gathers the (possibly out-of-order) results by
//   tag, and hands the assembled vector back on a writeback channel. Only one
//   request is in flight at a time. Operand and result bits are never
//   inspected or altered.
//
//   State table
//     IDLE  | waiting for a request; req_ready_o high once out of reset
//     ISSUE | lanes being issued and/or results being collected
//     WB    | all lanes returned; writeback presented until accepted
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid_i/req_ready_o         request handshake
//   req_a_i, req_b_i                NUM_LANE packed operands (lane i at [i*W +: W])
//   req_rm_i, req_reg_idxw_i,
//   req_warpid_i                    request side-band fields
//   add_valid_o/add_ready_i         issue handshake to the adder
//   add_a_o, add_b_o, add_rm_o,
//   add_ctrl_c_o, add_reg_idxw_o,
//   add_warpid_o                    current lane operands, tag = lane index
//   res_valid_i/res_ready_o         result handshake from the adder
//   res_result_i, res_fflags_i,
//   res_ctrl_c_i                    lane result, flags and returned tag
//   wb_valid_o/wb_ready_i           writeback handshake
//   wb_data_o, wb_fflags_o,
//   wb_reg_idxw_o, wb_warpid_o      assembled result and side-band fields
//   protocol_err_o                  one-cycle pulse on a bad/duplicate tag
module fp_add_issuer #(
  parameter int EXPWIDTH     = 5,
  parameter int PRECISION    = 3,
  parameter int W            = EXPWIDTH + PRECISION + 1,
  parameter int NUM_LANE     = 4,
  parameter int CTRL_C_WIDTH = 16,
  parameter int DEPTH_WARP   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [NUM_LANE*W-1:0]     req_a_i,
  input  logic [NUM_LANE*W-1:0]     req_b_i,
  input  logic [2:0]                req_rm_i,
  input  logic [7:0]                req_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]     req_warpid_i,
  output logic                      add_valid_o,
  input  logic                      add_ready_i,
  output logic [W-1:0]              add_a_o,
  output logic [W-1:0]              add_b_o,
  output logic [2:0]                add_rm_o,
  output logic [CTRL_C_WIDTH-1:0]   add_ctrl_c_o,
  output logic [7:0]                add_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]     add_warpid_o,
  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  input  logic [W-1:0]              res_result_i,
  input  logic [4:0]                res_fflags_i,
  input  logic [CTRL_C_WIDTH-1:0]   res_ctrl_c_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [NUM_LANE*W-1:0]     wb_data_o,
  output logic [4:0]                wb_fflags_o,
  output logic [7:0]                wb_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]     wb_warpid_o,
  output logic                      protocol_err_o
);

  localparam int LIDXW = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  // One extra count value marks "all lanes issued".
  localparam int CNTW  = $clog2(NUM_LANE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    live_q;
  logic [NUM_LANE*W-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [2:0]              rm_q, rm_d;
  logic [7:0]              idxw_q, idxw_d;
  logic [DEPTH_WARP-1:0]   warp_q, warp_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [NUM_LANE-1:0]     done_q, done_d;
  logic [4:0]              flags_q, flags_d;
  logic                    err_q, err_d;

  logic [LIDXW-1:0]        issue_lane, res_lane;
  logic                    req_fire, add_fire, res_fire, wb_fire, res_ok;

  assign issue_lane = cnt_q[LIDXW-1:0];
  assign res_lane   = res_ctrl_c_i[LIDXW-1:0];

  // live_q holds req_ready_o low until the first edge after reset release.
  assign req_ready_o = live_q && (state_q == IDLE);
  assign add_valid_o = (state_q == ISSUE) && (cnt_q < CNTW'(NUM_LANE));
  assign res_ready_o = (state_q == ISSUE);
  assign wb_valid_o  = (state_q == WB);

  assign req_fire = req_valid_i && req_ready_o;
  assign add_fire = add_valid_o && add_ready_i;
  assign res_fire = res_valid_i && res_ready_o;
  assign wb_fire  = wb_valid_o && wb_ready_i;

  // A result is usable only for an existing lane that has not yet returned.
  assign res_ok = (res_ctrl_c_i < CTRL_C_WIDTH'(NUM_LANE)) && !done_q[res_lane];

  assign add_a_o        = a_q[issue_lane*W +: W];
  assign add_b_o        = b_q[issue_lane*W +: W];
  assign add_rm_o       = rm_q;
  assign add_ctrl_c_o   = {{(CTRL_C_WIDTH-LIDXW){1'b0}}, issue_lane};
  assign add_reg_idxw_o = idxw_q;
  assign add_warpid_o   = warp_q;

  assign wb_data_o      = data_q;
  assign wb_fflags_o    = flags_q;
  assign wb_reg_idxw_o  = idxw_q;
  assign wb_warpid_o    = warp_q;
  assign protocol_err_o = err_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    rm_d    = rm_q;
    idxw_d  = idxw_q;
    warp_d  = warp_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    flags_d = flags_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          a_d     = req_a_i;
          b_d     = req_b_i;
          rm_d    = req_rm_i;
          idxw_d  = req_reg_idxw_i;
          warp_d  = req_warpid_i;
          cnt_d   = '0;
          done_d  = '0;
          flags_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (add_fire) cnt_d = cnt_q + CNTW'(1);
        if (res_fire) begin
          if (res_ok) begin
            data_d[res_lane*W +: W] = res_result_i;
            done_d[res_lane]        = 1'b1;
            flags_d                 = flags_q | res_fflags_i;
          end else begin
            err_d = 1'b1;
          end
        end
        // Leave on the edge that records the last result, so writeback is
        // visible in the very next cycle.
        if (&done_d) state_d = WB;
      end
      WB: begin
        if (wb_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      rm_q    <= '0;
      idxw_q  <= '0;
      warp_q  <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rm_q    <= rm_d;
      idxw_q  <= idxw_d;
      warp_q  <= warp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fp_add_issuer.sv
module tb_fp_add_issuer;
  localparam int W  = 9;
  localparam int NL = 4;
  localparam int CW = 16;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [NL*W-1:0]   req_a_i = '0, req_b_i = '0;
  logic [2:0]        req_rm_i = '0;
  logic [7:0]        req_reg_idxw_i = '0;
  logic [DW-1:0]     req_warpid_i = '0;
  logic              add_valid_o;
  logic              add_ready_i = 1'b0;
  logic [W-1:0]      add_a_o, add_b_o;
  logic [2:0]        add_rm_o;
  logic [CW-1:0]     add_ctrl_c_o;
  logic [7:0]        add_reg_idxw_o;
  logic [DW-1:0]     add_warpid_o;
  logic              res_valid_i = 1'b0;
  logic              res_ready_o;
  logic [W-1:0]      res_result_i = '0;
  logic [4:0]        res_fflags_i = '0;
  logic [CW-1:0]     res_ctrl_c_i = '0;
  logic              wb_valid_o;
  logic              wb_ready_i = 1'b0;
  logic [NL*W-1:0]   wb_data_o;
  logic [4:0]        wb_fflags_o;
  logic [7:0]        wb_reg_idxw_o;
  logic [DW-1:0]     wb_warpid_o;
  logic              protocol_err_o;

  fp_add_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i),
    .req_reg_idxw_i(req_reg_idxw_i), .req_warpid_i(req_warpid_i),
    .add_valid_o(add_valid_o), .add_ready_i(add_ready_i),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_rm_o(add_rm_o),
    .add_ctrl_c_o(add_ctrl_c_o), .add_reg_idxw_o(add_reg_idxw_o), .add_warpid_o(add_warpid_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_result_i(res_result_i), .res_fflags_i(res_fflags_i), .res_ctrl_c_i(res_ctrl_c_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_fflags_o(wb_fflags_o),
    .wb_reg_idxw_o(wb_reg_idxw_o), .wb_warpid_o(wb_warpid_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Error pulses seen vs. bad results the bench has sent.
  int err_seen = 0;
  int err_exp  = 0;
  always @(negedge clk) if (protocol_err_o) err_seen++;

  // Per-request scenario description.
  logic [W-1:0]  ra[NL], rb[NL], rv[NL];
  logic [4:0]    rf[NL];
  int            order[$];
  logic [2:0]    r_rm;
  logic [7:0]    r_idx;
  logic [DW-1:0] r_warp;
  int            stall_lane, stall_cyc, wb_stall, dup_tag;
  bit            inject, gaps, rnd_stall;

  function automatic logic [NL*W-1:0] pack(input logic [W-1:0] v[NL]);
    logic [NL*W-1:0] p;
    for (int i = 0; i < NL; i++) p[i*W +: W] = v[i];
    return p;
  endfunction

  task automatic set_default();
    int perm[NL];
    for (int i = 0; i < NL; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom);
      rv[i] = W'($urandom); rf[i] = 5'($urandom);
      perm[i] = i;
    end
    for (int i = NL - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    order.delete();
    for (int i = 0; i < NL; i++) order.push_back(perm[i]);
    r_rm = 3'($urandom); r_idx = 8'($urandom); r_warp = DW'($urandom);
    stall_lane = -1; stall_cyc = 0; wb_stall = 0; dup_tag = 0;
    inject = 0; gaps = 0; rnd_stall = 0;
  endtask

  task automatic set_inorder();
    order.delete();
    for (int i = 0; i < NL; i++) order.push_back(i);
  endtask

  // Runs one request from transfer through writeback; entered and left at a negedge.
  task automatic run_req(input string nm);
    bit            issued[NL];
    bit            acc[NL];
    logic [W-1:0]  exp_data[NL];
    logic [4:0]    exp_fl;
    int            next_lane, cnt, stall_n, inj_state, last_cyc, res_tag;
    bit            fire_add, fire_res;
    exp_fl = '0; next_lane = 0; stall_n = 0; inj_state = 0; last_cyc = -10; res_tag = 0;
    for (int i = 0; i < NL; i++) begin issued[i] = 0; acc[i] = 0; exp_data[i] = '0; end

    req_a_i = pack(ra); req_b_i = pack(rb);
    req_rm_i = r_rm; req_reg_idxw_i = r_idx; req_warpid_i = r_warp;
    req_valid_i = 1'b1;
    cnt = 0;
    while (!req_ready_o && cnt < 50) begin @(negedge clk); cnt++; end
    chk({nm, "-req_ready"}, 64'(req_ready_o), 64'(1));
    @(negedge clk);
    req_valid_i = 1'b0;
    req_a_i = {NL{W'($urandom)}}; req_b_i = {NL{W'($urandom)}};
    req_rm_i = 3'($urandom); req_reg_idxw_i = 8'($urandom); req_warpid_i = DW'($urandom);
    chk({nm, "-first_issue"}, 64'(add_valid_o), 64'(1));

    cnt = 0;
    while (!wb_valid_o && cnt < 300) begin
      chk({nm, "-res_ready"}, 64'(res_ready_o), 64'(1));
      fire_add = 0;
      if (next_lane < NL) begin
        chk({nm, "-add_valid"}, 64'(add_valid_o), 64'(1));
        chk({nm, "-add_tag"}, 64'(add_ctrl_c_o), 64'(next_lane));
        chk({nm, "-add_a"}, 64'(add_a_o), 64'(ra[next_lane]));
        chk({nm, "-add_b"}, 64'(add_b_o), 64'(rb[next_lane]));
        chk({nm, "-add_side"}, 64'({add_rm_o, add_reg_idxw_o, add_warpid_o}),
            64'({r_rm, r_idx, r_warp}));
        if (next_lane == stall_lane && stall_n < stall_cyc) begin
          add_ready_i = 1'b0; stall_n++;
        end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
          add_ready_i = 1'b0;
        end else begin
          add_ready_i = 1'b1; fire_add = 1;
        end
      end else begin
        chk({nm, "-add_drop"}, 64'(add_valid_o), 64'(0));
        add_ready_i = 1'($urandom);
      end

      res_valid_i = 1'b0; fire_res = 0;
      res_ctrl_c_i = CW'($urandom_range(0, 3)); res_result_i = W'($urandom); res_fflags_i = 5'h1f;
      if (inj_state == 1) begin
        res_valid_i = 1'b1; res_ctrl_c_i = CW'(dup_tag); res_result_i = '1;
        inj_state = 2; err_exp++;
      end else if (inj_state == 2) begin
        res_valid_i = 1'b1; res_ctrl_c_i = CW'(5); res_result_i = '1;
        inj_state = 3; err_exp++;
      end else if (order.size() > 0 &&
                   (issued[order[0]] || (fire_add && order[0] == next_lane)) &&
                   (!gaps || $urandom_range(0, 2) != 0)) begin
        res_tag = order[0];
        res_valid_i = 1'b1; res_ctrl_c_i = CW'(res_tag);
        res_result_i = rv[res_tag]; res_fflags_i = rf[res_tag];
        fire_res = 1;
      end

      @(posedge clk);
      if (fire_add) begin issued[next_lane] = 1; next_lane++; end
      if (fire_res) begin
        void'(order.pop_front());
        if (!acc[res_tag]) begin
          acc[res_tag] = 1; exp_data[res_tag] = rv[res_tag]; exp_fl = exp_fl | rf[res_tag];
        end
        last_cyc = cnt;
        if (inject && res_tag == dup_tag && inj_state == 0) inj_state = 1;
      end
      @(negedge clk);
      res_valid_i = 1'b0;
      cnt++;
    end

    chk({nm, "-wb_valid"}, 64'(wb_valid_o), 64'(1));
    chk({nm, "-results_left"}, 64'(order.size()), 64'(0));
    chk({nm, "-wb_latency"}, 64'(cnt - last_cyc), 64'(1));
    chk({nm, "-res_ready_wb"}, 64'(res_ready_o), 64'(0));
    for (int s = 0; s <= wb_stall; s++) begin
      wb_ready_i = (s == wb_stall);
      chk({nm, "-wb_data"}, 64'(wb_data_o), 64'(pack(exp_data)));
      chk({nm, "-wb_side"}, 64'({wb_valid_o, wb_fflags_o, wb_reg_idxw_o, wb_warpid_o}),
          64'({1'b1, exp_fl, r_idx, r_warp}));
      @(negedge clk);
    end
    wb_ready_i = 1'b0;
    chk({nm, "-wb_done"}, 64'(wb_valid_o), 64'(0));
    chk({nm, "-idle_ready"}, 64'(req_ready_o), 64'(1));
    chk({nm, "-err_count"}, 64'(err_seen), 64'(err_exp));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "-ctrl"}, 64'({req_ready_o, add_valid_o, res_ready_o, wb_valid_o, protocol_err_o}), 64'(0));
    chk({nm, "-data"}, 64'(|{add_a_o, add_b_o, add_rm_o, add_ctrl_c_o, add_reg_idxw_o, add_warpid_o,
                             wb_data_o, wb_fflags_o, wb_reg_idxw_o, wb_warpid_o}), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1 chk("rel_ready_early", 64'(req_ready_o), 64'(0));
    @(negedge clk);
    chk("rel_ready", 64'(req_ready_o), 64'(1));

    // Basic: 1.0 + 1.0 on every lane, results returned in order.
    set_default(); set_inorder();
    for (int i = 0; i < NL; i++) begin ra[i] = 9'h078; rb[i] = 9'h078; rv[i] = 9'h080; rf[i] = 5'h00; end
    run_req("basic");

    // Backpressure on lane 2 issue and on writeback.
    set_default(); stall_lane = 2; stall_cyc = 3; wb_stall = 2;
    run_req("bp");

    // Out-of-order returns.
    set_default();
    order.delete(); order.push_back(3); order.push_back(0); order.push_back(2); order.push_back(1);
    rv[3] = 9'h101; rv[0] = 9'h102; rv[2] = 9'h103; rv[1] = 9'h104;
    run_req("ooo");

    // Duplicate tag 1 and out-of-range tag 5.
    set_default(); set_inorder(); inject = 1; dup_tag = 1;
    for (int i = 0; i < NL; i++) rf[i] = 5'h00;
    run_req("err");

    // Flag accumulation, issued back-to-back after the previous writeback.
    set_default();
    rf[0] = 5'h01; rf[1] = 5'h00; rf[2] = 5'h00; rf[3] = 5'h04;
    run_req("flags");

    // Reset in the middle of issue.
    set_default();
    req_a_i = pack(ra); req_b_i = pack(rb); req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0; add_ready_i = 1'b1;
    @(negedge clk);
    add_ready_i = 1'b0;
    @(negedge clk);
    chk("mid_state", 64'(res_ready_o), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    res_valid_i = 1'b1; res_ctrl_c_i = '0; res_result_i = '1; res_fflags_i = 5'h1f;
    #1 chk("mr_ready_early", 64'({req_ready_o, res_ready_o}), 64'(0));
    @(negedge clk);
    chk("mr_ready", 64'({req_ready_o, res_ready_o, wb_valid_o, protocol_err_o}), 64'(4'b1000));
    res_valid_i = 1'b0;
    chk("mr_err_count", 64'(err_seen), 64'(err_exp));

    // Randomized requests.
    for (int k = 0; k < 25; k++) begin
      set_default();
      rnd_stall = 1; gaps = 1; wb_stall = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin inject = 1; dup_tag = order[0]; end
      if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
      run_req($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_add_issuer.md
FP_ADD_ISSUER -- requirements
Module: fp_add_issuer

Interface
REQ-001 SHALL have parameters: EXPWIDTH, default 5, exponent bits; PRECISION, default 3, stored mantissa bits; W = EXPWIDTH+PRECISION+1 (derived); NUM_LANE, default 4, lanes per request (power of 2); CTRL_C_WIDTH, default 16, tag width; DEPTH_WARP, default 4, warp-id width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_a_i, req_b_i  in  NUM_LANE*W  operands; lane i at [i*W +: W]
- req_rm_i  in  3  rounding mode
- req_reg_idxw_i  in  8  destination register
- req_warpid_i  in  DEPTH_WARP  warp id
- add_valid_o / add_ready_i  out/in  1  issue handshake to adder
- add_a_o, add_b_o  out  W  lane operands
- add_rm_o  out  3  latched rm
- add_ctrl_c_o  out  CTRL_C_WIDTH  tag: zero-extended lane index
- add_reg_idxw_o  out  8; add_warpid_o  out  DEPTH_WARP  latched request fields
- res_valid_i / res_ready_o  in/out  1  result handshake from adder
- res_result_i  in  W; res_fflags_i  in  5; res_ctrl_c_i  in  CTRL_C_WIDTH  returned tag
- wb_valid_o / wb_ready_i  out/in  1  writeback handshake
- wb_data_o  out  NUM_LANE*W; wb_fflags_o  out  5; wb_reg_idxw_o  out  8; wb_warpid_o  out  DEPTH_WARP
- protocol_err_o  out  1  one-cycle error pulse

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WB; one request in flight.
REQ-004 req_ready_o SHALL be 1 only in IDLE and only from the first clk edge after rst_n deasserts; transfer = req_valid_i && req_ready_o.
REQ-005 On transfer SHALL latch operands, rm, reg_idxw, warpid; clear lane counter, done mask, fflags accumulator; go to ISSUE; add_valid_o 1 next cycle.
REQ-006 In ISSUE SHALL drive lane L = issue counter onto add_a_o/add_b_o, add_ctrl_c_o = L; hold all add_* stable while add_valid_o && !add_ready_i.
REQ-007 On add handshake SHALL increment counter; after lane NUM_LANE-1 accepted, add_valid_o SHALL drop next cycle, state stays ISSUE until all results return.
REQ-008 res_ready_o SHALL be 1 in ISSUE, 0 in IDLE and WB.
REQ-009 On result handshake with tag T < NUM_LANE and done[T]=0: store res_result_i in lane T slot, set done[T], OR res_fflags_i into accumulator.
REQ-010 Result with T >= NUM_LANE or done[T]=1 SHALL be dropped (no state change) and pulse protocol_err_o for one cycle.
REQ-011 Results SHALL be accepted in any order and on the same cycle as an issue handshake, including the cycle lane is issued.
REQ-012 When done mask becomes all ones SHALL enter WB next cycle; wb_valid_o=1, wb_data_o = collected lanes, wb_fflags_o = accumulator, wb_reg_idxw_o/wb_warpid_o = latched.
REQ-013 wb_* SHALL hold stable until wb_valid_o && wb_ready_i; then IDLE next cycle, req_ready_o=1 that cycle.
REQ-014 Minimum latency: request transfer cycle 0 -> first issue cycle 1 -> wb_valid_o no earlier than cycle after last result accepted.
REQ-015 Block SHALL NOT inspect or modify FP values; operands and results pass bit-exact.

Reset
REQ-016 rst_n low SHALL immediately force: state IDLE, req_ready_o 0, add_valid_o 0, res_ready_o 0, wb_valid_o 0, protocol_err_o 0, all data/ctrl outputs 0, counter/mask/accumulator 0.
REQ-017 Reset mid-operation SHALL abandon the request; no writeback of partial results; results arriving after reset release in IDLE are not accepted.

Verification
REQ-018 Reset: assert rst_n=0 mid-ISSUE -> all outputs 0 immediately; release -> req_ready_o=1 one cycle later.
REQ-019 Basic: lanes a=0x078 (1.0), b=0x078, NUM_LANE=4, adder model returns 0x080 in order -> wb_data_o = 4x0x080, wb_fflags_o=0, tags 0,1,2,3 issued.
REQ-020 Backpressure: add_ready_i low 3 cycles on lane 2 -> add_a_o/add_ctrl_c_o held (tag 2) until accepted; wb_ready_i low 2 cycles -> wb_* stable.
REQ-021 Out-of-order: results tagged 3,0,2,1 with values 0x101,0x102,0x103,0x104 -> wb_data_o lane3=0x101, lane0=0x102, lane2=0x103, lane1=0x104.
REQ-022 Errors: duplicate tag 1 and tag 5 returned -> protocol_err_o pulses twice, lane 1 keeps first value, writeback waits for remaining lanes.
REQ-023 Flags: lane 0 fflags 0x01, lane 3 fflags 0x04 -> wb_fflags_o=0x05; back-to-back requests -> second accepted cycle after wb handshake.
